syn_fifo_wr_ctrl: RTL and testbench

- Write-side controller for one syn_fifo instance.
- Round-robin arbitrates NREQ producers onto the single FIFO write port.
- Throttles to the priority requester once the FIFO reports almost-full.
- Sequences the FIFO's reset-time AF/AE offset (X) programming, using DAF plus the data bus, on a runtime configuration request.

---
 rtl/syn_fifo_ctrl_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/syn_fifo_wr_ctrl.sv | 172 +++++++++++++++++
 tb/tb_syn_fifo_wr_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/syn_fifo_ctrl_pkg.sv
// Shared types and helpers for the syn_fifo write-side controller.
package syn_fifo_ctrl_pkg;

  typedef enum logic [2:0] {
    S_REL,
    S_RUN,
    S_DRAIN,
    S_PRST,
    S_LOAD,
    S_XREL
  } ctrl_state_e;

  localparam int unsigned X_MIN = 1;

  // X must leave room on both sides of the midpoint: X_MIN..entries/2-1.
  function automatic logic x_legal(input int unsigned x, input int unsigned entries);
    return (x >= X_MIN) && (x <= (entries / 2) - 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first eligible index at or after the pointer.
module rr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  i_eligible,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_grant,
  output logic [PTR_W-1:0] o_ptr_nxt
);

  int unsigned w_idx;
  logic        w_found;

  // Scan from the pointer with wrap; next pointer is one past the winner.
  always_comb begin
    o_grant   = '0;
    o_ptr_nxt = i_ptr;
    w_found   = 1'b0;
    w_idx     = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_idx = (32'(i_ptr) + i) % NREQ;
      if (!w_found && i_eligible[PTR_W'(w_idx)]) begin
        w_found                 = 1'b1;
        o_grant[PTR_W'(w_idx)]  = 1'b1;
        o_ptr_nxt               = PTR_W'((w_idx + 1) % NREQ);
      end
    end
  end

endmodule

// File: rtl/syn_fifo_wr_ctrl.sv
// Write-side controller for one syn_fifo: round-robin write arbitration,
// almost-full throttling to requester 0, and X (AF/AE offset) programming.
module syn_fifo_wr_ctrl
  import syn_fifo_ctrl_pkg::*;
#(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned FIFO_ENTRIES = 16,
  parameter int unsigned LOAD_CYCLES  = 2,
  parameter int unsigned X_DEFAULT    = 4
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  output logic [NREQ-1:0]            req_ready,
  input  logic                       cfg_valid,
  input  logic [DATA_WIDTH-1:0]      cfg_x,
  input  logic                       cfg_use_default,
  output logic                       cfg_ready,
  output logic                       cfg_err,
  input  logic                       fifo_full,
  input  logic                       fifo_af,
  input  logic                       fifo_empty,
  output logic                       fifo_rst_n,
  output logic                       fifo_daf,
  output logic                       fifo_wr_en,
  output logic [DATA_WIDTH-1:0]      fifo_data,
  output logic [DATA_WIDTH-1:0]      x_cur,
  output logic                       busy
);

  localparam int unsigned PTR_W = $clog2(NREQ);
  localparam int unsigned CNT_W = $clog2(LOAD_CYCLES + 1);

  ctrl_state_e           r_state;
  logic [PTR_W-1:0]      r_ptr;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_x_tgt;
  logic                  r_tgt_dflt;
  logic [DATA_WIDTH-1:0] r_x_cur;
  logic                  r_cfg_err;

  logic [NREQ-1:0]       w_elig;
  logic [NREQ-1:0]       w_grant;
  logic [PTR_W-1:0]      w_ptr_nxt;
  logic [DATA_WIDTH-1:0] w_gnt_data;
  logic                  w_cfg_ok;

  assign w_cfg_ok = cfg_use_default || x_legal(32'(cfg_x), FIFO_ENTRIES);
  assign x_cur    = r_x_cur;
  assign cfg_err  = r_cfg_err;

  // Eligibility: AF narrows to requester 0, full or a pending cfg blocks all.
  always_comb begin
    w_elig = req_valid;
    if (fifo_af) begin
      w_elig = req_valid & NREQ'(1);
    end
    if (fifo_full || cfg_valid || (r_state != S_RUN)) begin
      w_elig = '0;
    end
  end

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .i_eligible (w_elig),
    .i_ptr      (r_ptr),
    .o_grant    (w_grant),
    .o_ptr_nxt  (w_ptr_nxt)
  );

  // Select the granted requester's data slice.
  always_comb begin
    w_gnt_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_gnt_data = w_gnt_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Controller state, RR pointer, programming target and x_cur.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      r_state    <= S_REL;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_x_tgt    <= '0;
      r_tgt_dflt <= 1'b1;
      r_x_cur    <= DATA_WIDTH'(X_DEFAULT);
      r_cfg_err  <= 1'b0;
    end else begin
      r_cfg_err <= 1'b0;
      case (r_state)
        S_REL: r_state <= S_RUN;
        S_RUN: begin
          if (cfg_valid) begin
            if (w_cfg_ok) begin
              r_x_tgt    <= cfg_use_default ? DATA_WIDTH'(X_DEFAULT) : cfg_x;
              r_tgt_dflt <= cfg_use_default;
              r_state    <= S_DRAIN;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end else if (|w_grant) begin
            r_ptr <= w_ptr_nxt;
          end
        end
        S_DRAIN: begin
          if (fifo_empty) begin
            r_state <= S_PRST;
          end
        end
        S_PRST: begin
          r_cnt   <= CNT_W'(LOAD_CYCLES - 1);
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          if (r_cnt == '0) begin
            r_state <= S_XREL;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_XREL: begin
          r_x_cur <= r_x_tgt;
          r_state <= S_RUN;
        end
        default: r_state <= S_REL;
      endcase
    end
  end

  // Per-state FIFO pin drive; grants are combinational only in S_RUN.
  always_comb begin
    fifo_rst_n = 1'b1;
    fifo_daf   = 1'b1;
    fifo_wr_en = 1'b0;
    fifo_data  = '0;
    req_ready  = '0;
    cfg_ready  = 1'b0;
    busy       = 1'b1;
    case (r_state)
      S_REL: fifo_rst_n = 1'b0;
      S_RUN: begin
        busy       = 1'b0;
        cfg_ready  = 1'b1;
        req_ready  = w_grant;
        fifo_wr_en = |w_grant;
        fifo_data  = w_gnt_data;
      end
      S_PRST: begin
        fifo_rst_n = 1'b0;
        fifo_data  = r_x_tgt;
      end
      S_LOAD: begin
        fifo_rst_n = 1'b0;
        fifo_daf   = r_tgt_dflt;
        fifo_data  = r_x_tgt;
      end
      S_XREL: begin
        fifo_daf  = r_tgt_dflt;
        fifo_data = r_x_tgt;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_syn_fifo_wr_ctrl.sv
// Self-checking bench for syn_fifo_wr_ctrl with a behavioural arbitration model
// and a simple model of the FIFO's X register latched on reset release.
module tb_syn_fifo_wr_ctrl;

  localparam int NREQ    = 4;
  localparam int DW      = 8;
  localparam int ENTRIES = 16;
  localparam int LOADC   = 2;
  localparam int XDEF    = 4;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic              cfg_valid = 1'b0;
  logic [DW-1:0]     cfg_x = '0;
  logic              cfg_use_default = 1'b0;
  logic              cfg_ready;
  logic              cfg_err;
  logic              fifo_full = 1'b0;
  logic              fifo_af = 1'b0;
  logic              fifo_empty = 1'b1;
  logic              fifo_rst_n;
  logic              fifo_daf;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_data;
  logic [DW-1:0]     x_cur;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;
  int m_ptr = 0;
  int m_x = XDEF;
  logic [DW-1:0] fifo_x = '0;
  logic          prev_rst_n = 1'b1;

  syn_fifo_wr_ctrl #(
    .NREQ(NREQ), .DATA_WIDTH(DW), .FIFO_ENTRIES(ENTRIES),
    .LOAD_CYCLES(LOADC), .X_DEFAULT(XDEF)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .cfg_valid(cfg_valid), .cfg_x(cfg_x), .cfg_use_default(cfg_use_default),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err),
    .fifo_full(fifo_full), .fifo_af(fifo_af), .fifo_empty(fifo_empty),
    .fifo_rst_n(fifo_rst_n), .fifo_daf(fifo_daf), .fifo_wr_en(fifo_wr_en),
    .fifo_data(fifo_data), .x_cur(x_cur), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  // FIFO model: X is captured on the first edge that sees reset released.
  always @(posedge sys_clk) begin
    if (fifo_rst_n === 1'b1 && prev_rst_n === 1'b0)
      fifo_x <= fifo_daf ? DW'(XDEF) : fifo_data;
    prev_rst_n <= fifo_rst_n;
  end

  // Reference: first eligible index scanning from the pointer, or -1.
  function automatic int exp_winner(logic [NREQ-1:0] v, logic af, logic full, int ptr);
    if (full) return -1;
    for (int off = 0; off < NREQ; off++) begin
      int k;
      k = (ptr + off) % NREQ;
      if (v[k] && (!af || k == 0)) return k;
    end
    return -1;
  endfunction

  // Compare one RUN-state arbitration cycle against the model and advance it.
  task automatic check_arb(input string tag);
    int k;
    logic [NREQ-1:0] e_rdy;
    logic [DW-1:0]   e_data;
    k = exp_winner(req_valid, fifo_af, fifo_full, m_ptr);
    e_rdy  = (k >= 0) ? NREQ'(1 << k) : '0;
    e_data = '0;
    if (k >= 0) e_data = req_data[k*DW +: DW];
    n_checks++;
    if (req_ready !== e_rdy || fifo_wr_en !== (k >= 0) || fifo_data !== e_data) begin
      n_errors++;
      $display("FAIL %s: ready=%b wr_en=%b data=%h, want ready=%b wr_en=%b data=%h",
               tag, req_ready, fifo_wr_en, fifo_data, e_rdy, (k >= 0), e_data);
    end
    if (k >= 0) m_ptr = (k + 1) % NREQ;
  endtask

  task automatic test_reset();
    sys_rst = 1'b0; req_valid = '1; cfg_valid = 1'b1; cfg_x = 8'd3; fifo_empty = 1'b1;
    repeat (5) @(negedge sys_clk);
    #1;
    n_checks++;
    if ({fifo_rst_n, fifo_daf, fifo_wr_en, req_ready, cfg_ready, cfg_err, busy} !== 10'b0100000001) begin
      n_errors++;
      $display("FAIL reset_flags: rst_n=%b daf=%b wr_en=%b ready=%b cfg_ready=%b cfg_err=%b busy=%b, want 0 1 0 0000 0 0 1",
               fifo_rst_n, fifo_daf, fifo_wr_en, req_ready, cfg_ready, cfg_err, busy);
    end
    n_checks++;
    if (fifo_data !== 8'h00 || x_cur !== DW'(XDEF)) begin
      n_errors++;
      $display("FAIL reset_data: data=%h x_cur=%0d, want 00 %0d", fifo_data, x_cur, XDEF);
    end
    @(negedge sys_clk);
    req_valid = '0; cfg_valid = 1'b0; sys_rst = 1'b1;
    #1;
    n_checks++;
    if (fifo_rst_n !== 1'b0 || busy !== 1'b1 || fifo_daf !== 1'b1) begin
      n_errors++;
      $display("FAIL boot_rel: rst_n=%b busy=%b daf=%b, want 0 1 1", fifo_rst_n, busy, fifo_daf);
    end
    @(negedge sys_clk); #1;
    n_checks++;
    if (fifo_rst_n !== 1'b1 || busy !== 1'b0 || cfg_ready !== 1'b1 || fifo_daf !== 1'b1) begin
      n_errors++;
      $display("FAIL boot_run: rst_n=%b busy=%b cfg_ready=%b daf=%b, want 1 0 1 1",
               fifo_rst_n, busy, cfg_ready, fifo_daf);
    end
    @(negedge sys_clk); #1;
    n_checks++;
    if (fifo_x !== DW'(XDEF)) begin
      n_errors++;
      $display("FAIL boot_fifo_x: got %0d want %0d", fifo_x, XDEF);
    end
    m_ptr = 0;
    m_x   = XDEF;
  endtask

  task automatic test_round_robin();
    req_data = 32'h43322110;
    fifo_af = 1'b0; fifo_full = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge sys_clk);
      req_valid = '1;
      #1;
      check_arb("rr_fair");
    end
    @(negedge sys_clk);
    req_valid = '0;
  endtask

  task automatic test_af_throttle();
    req_data = 32'hA4B3C2D1;
    @(negedge sys_clk); fifo_af = 1'b1; req_valid = 4'b1110; #1; check_arb("af_no_prio");
    @(negedge sys_clk); req_valid = 4'b1111; #1; check_arb("af_prio");
    @(negedge sys_clk); fifo_full = 1'b1; #1; check_arb("full_af");
    @(negedge sys_clk); fifo_af = 1'b0; #1; check_arb("full_only");
    @(negedge sys_clk); fifo_full = 1'b0; req_valid = '0;
  endtask

  task automatic test_random_arb();
    for (int c = 0; c < 60; c++) begin
      @(negedge sys_clk);
      req_valid = NREQ'($urandom);
      req_data  = $urandom;
      fifo_af   = ($urandom_range(0, 3) == 0);
      fifo_full = ($urandom_range(0, 7) == 0);
      #1;
      check_arb("rr_random");
    end
    @(negedge sys_clk);
    req_valid = '0; fifo_af = 1'b0; fifo_full = 1'b0;
  endtask

  // One configuration request; DRAIN is held for 1+drain cycles before empty.
  task automatic do_cfg(input logic [DW-1:0] x, input logic dflt, input int drain);
    logic legal;
    int   x_exp, rst_low, daf_low, data_bad, prog;
    legal = dflt || (x >= 1 && x <= ENTRIES / 2 - 1);
    x_exp = dflt ? XDEF : int'(x);
    @(negedge sys_clk);
    cfg_valid = 1'b1; cfg_x = x; cfg_use_default = dflt; req_valid = '1; fifo_empty = 1'b0;
    #1;
    n_checks++;
    if (cfg_ready !== 1'b1 || req_ready !== '0 || fifo_wr_en !== 1'b0) begin
      n_errors++;
      $display("FAIL cfg_prio x=%0d: cfg_ready=%b ready=%b wr_en=%b, want 1 0000 0",
               x, cfg_ready, req_ready, fifo_wr_en);
    end
    @(negedge sys_clk);
    cfg_valid = 1'b0;
    if (!legal) begin
      req_valid = '0; fifo_empty = 1'b1;
      #1;
      n_checks++;
      if (cfg_err !== 1'b1 || busy !== 1'b0 || fifo_rst_n !== 1'b1 || x_cur !== DW'(m_x)) begin
        n_errors++;
        $display("FAIL cfg_reject x=%0d: err=%b busy=%b rst_n=%b x_cur=%0d, want 1 0 1 %0d",
                 x, cfg_err, busy, fifo_rst_n, x_cur, m_x);
      end
      @(negedge sys_clk); #1;
      n_checks++;
      if (cfg_err !== 1'b0 || fifo_rst_n !== 1'b1 || x_cur !== DW'(m_x)) begin
        n_errors++;
        $display("FAIL cfg_err_pulse x=%0d: err=%b rst_n=%b x_cur=%0d, want 0 1 %0d",
                 x, cfg_err, fifo_rst_n, x_cur, m_x);
      end
      return;
    end
    #1;
    for (int d = 0; d <= drain; d++) begin
      if (d > 0) begin @(negedge sys_clk); #1; end
      n_checks++;
      if (busy !== 1'b1 || cfg_ready !== 1'b0 || req_ready !== '0 || fifo_rst_n !== 1'b1 || cfg_err !== 1'b0) begin
        n_errors++;
        $display("FAIL drain x=%0d d=%0d: busy=%b cfg_ready=%b ready=%b rst_n=%b err=%b, want 1 0 0000 1 0",
                 x, d, busy, cfg_ready, req_ready, fifo_rst_n, cfg_err);
      end
    end
    fifo_empty = 1'b1; req_valid = '0;
    rst_low = 0; daf_low = 0; data_bad = 0; prog = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge sys_clk); #1;
      if (busy === 1'b0) break;
      prog++;
      if (fifo_rst_n === 1'b0) rst_low++;
      if (fifo_daf === 1'b0) daf_low++;
      if (fifo_data !== DW'(x_exp)) data_bad++;
    end
    n_checks++;
    if (prog != 2 + LOADC || rst_low != 1 + LOADC || daf_low != (dflt ? 0 : LOADC + 1) || data_bad != 0) begin
      n_errors++;
      $display("FAIL prog_seq x=%0d dflt=%b: cycles=%0d rst_low=%0d daf_low=%0d data_bad=%0d, want %0d %0d %0d 0",
               x, dflt, prog, rst_low, daf_low, data_bad, 2 + LOADC, 1 + LOADC, dflt ? 0 : LOADC + 1);
    end
    m_x = x_exp;
    n_checks++;
    if (x_cur !== DW'(m_x) || fifo_x !== DW'(m_x) || fifo_daf !== 1'b1 || fifo_data !== 8'h00 || cfg_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL prog_done x=%0d: x_cur=%0d fifo_x=%0d daf=%b data=%h cfg_ready=%b, want %0d %0d 1 00 1",
               x, x_cur, fifo_x, fifo_daf, fifo_data, cfg_ready, m_x, m_x);
    end
  endtask

  task automatic test_program_x6();
    do_cfg(8'd6, 1'b0, 3);
  endtask

  task automatic test_sweep_illegal();
    for (int i = 1; i <= 7; i++) do_cfg(DW'(i), 1'b0, 0);
    do_cfg(8'd0, 1'b0, 0);
    do_cfg(8'd8, 1'b0, 0);
    do_cfg(8'd0, 1'b1, 1);
    for (int r = 0; r < 6; r++) do_cfg(DW'($urandom_range(0, 15)), 1'b0, $urandom_range(0, 2));
    do_cfg(8'd2, 1'b0, 0);
  endtask

  task automatic test_reset_mid();
    logic seen;
    @(negedge sys_clk);
    cfg_valid = 1'b1; cfg_x = 8'd5; cfg_use_default = 1'b0; fifo_empty = 1'b1; req_valid = '0;
    @(negedge sys_clk);
    cfg_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge sys_clk); #1;
      if (fifo_rst_n === 1'b0 && fifo_daf === 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL mid_load_timeout: load phase not observed within 10 cycles");
    end
    sys_rst = 1'b0;
    @(negedge sys_clk); #1;
    n_checks++;
    if (fifo_rst_n !== 1'b0 || fifo_daf !== 1'b1 || fifo_data !== 8'h00 || busy !== 1'b1 ||
        cfg_ready !== 1'b0 || x_cur !== DW'(XDEF)) begin
      n_errors++;
      $display("FAIL mid_abort: rst_n=%b daf=%b data=%h busy=%b cfg_ready=%b x_cur=%0d, want 0 1 00 1 0 %0d",
               fifo_rst_n, fifo_daf, fifo_data, busy, cfg_ready, x_cur, XDEF);
    end
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk); #1;
    n_checks++;
    if (busy !== 1'b0 || x_cur !== DW'(XDEF)) begin
      n_errors++;
      $display("FAIL mid_rerun: busy=%b x_cur=%0d, want 0 %0d", busy, x_cur, XDEF);
    end
    @(negedge sys_clk); #1;
    n_checks++;
    if (fifo_x !== DW'(XDEF)) begin
      n_errors++;
      $display("FAIL mid_fifo_x: got %0d want %0d", fifo_x, XDEF);
    end
    m_ptr = 0;
    m_x   = XDEF;
    req_data = 32'h88776655;
    req_valid = '1; #1;
    check_arb("ptr_after_reset");
    @(negedge sys_clk);
    req_valid = '0;
  endtask

  task automatic test_back_to_back();
    test_random_arb();
    do_cfg(8'd3, 1'b0, 1);
    test_random_arb();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_af_throttle();
    test_random_arb();
    test_program_x6();
    test_sweep_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
